// File: rtl/puntaje_ctrl.sv
// puntaje_ctrl: game score keeper.
// Counts scoring events as a 3-digit BCD value, keeps the session record and
// drives three seven-segment patterns for the downstream display mux.
// Optional macro PUNTAJE_BLANK_CEROS_EN blanks leading zeros on the display.
module puntaje_ctrl #(
  parameter logic [11:0] MAX_BCD           = 12'h999,
  parameter logic [3:0]  PUNTOS_POR_EVENTO = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  presente,
  input  logic        punto,
  output logic [20:0] display_puntaje,
  output logic [11:0] puntaje_bcd,
  output logic [11:0] record_bcd,
  output logic        nuevo_record,
  output logic        saturado
);

  typedef enum logic [2:0] {
    OFF  = 3'd0,
    WLCM = 3'd1,
    CH   = 3'd2,
    GAME = 3'd3,
    WL   = 3'd4,
    PA   = 3'd5
  } estado_t;

`ifdef PUNTAJE_BLANK_CEROS_EN
  localparam logic [20:0] DISPLAY_RESET = {7'h00, 7'h00, 7'h7E};
`else
  localparam logic [20:0] DISPLAY_RESET = {7'h7E, 7'h7E, 7'h7E};
`endif

  logic [11:0] r_puntaje;
  logic [11:0] r_record;
  logic        r_nuevo;
  logic        r_sat;
  logic        r_punto_q;
  logic [2:0]  r_estado;
  logic [20:0] r_display;

  logic        w_evento;
  logic        w_entra_wl;
  logic [4:0]  w_u_raw, w_t_raw, w_h_raw;
  logic        w_cu, w_ct, w_ch;
  logic [3:0]  w_u_dig, w_t_dig, w_h_dig;
  logic [11:0] w_suma;
  logic [11:0] w_suma_sat;
  logic [11:0] w_siguiente;
  logic [20:0] w_display;

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_seg = 7'h7E;
      4'd1:    f_seg = 7'h30;
      4'd2:    f_seg = 7'h6D;
      4'd3:    f_seg = 7'h79;
      4'd4:    f_seg = 7'h33;
      4'd5:    f_seg = 7'h5B;
      4'd6:    f_seg = 7'h5F;
      4'd7:    f_seg = 7'h70;
      4'd8:    f_seg = 7'h7F;
      4'd9:    f_seg = 7'h7B;
      default: f_seg = 7'h01;
    endcase
  endfunction

  // A held punto counts once; rises outside GAME are simply dropped.
  assign w_evento   = punto & ~r_punto_q & (presente == GAME);
  assign w_entra_wl = (presente == WL) & (r_estado != WL);

  // BCD ripple add of the per-event increment, digit by digit.
  assign w_u_raw = {1'b0, r_puntaje[3:0]} + {1'b0, PUNTOS_POR_EVENTO};
  assign w_cu    = (w_u_raw > 5'd9);
  assign w_u_dig = w_cu ? 4'(w_u_raw - 5'd10) : w_u_raw[3:0];
  assign w_t_raw = {1'b0, r_puntaje[7:4]} + {4'd0, w_cu};
  assign w_ct    = (w_t_raw > 5'd9);
  assign w_t_dig = w_ct ? 4'(w_t_raw - 5'd10) : w_t_raw[3:0];
  assign w_h_raw = {1'b0, r_puntaje[11:8]} + {4'd0, w_ct};
  assign w_ch    = (w_h_raw > 5'd9);
  assign w_h_dig = w_ch ? 4'(w_h_raw - 5'd10) : w_h_raw[3:0];
  assign w_suma  = {w_h_dig, w_t_dig, w_u_dig};

  // Saturate instead of wrapping when the sum overflows the hundreds digit.
  assign w_suma_sat = (w_ch || (w_suma > MAX_BCD)) ? MAX_BCD : w_suma;

  // Next score as a function of the game state.
  always_comb begin
    w_siguiente = r_puntaje;
    case (presente)
      GAME:    if (w_evento) w_siguiente = w_suma_sat;
      PA, WL:  w_siguiente = r_puntaje;
      default: w_siguiente = '0;
    endcase
  end

  // Seven-segment encoding of the current score, optionally blanking leading zeros.
  always_comb begin
    w_display = {f_seg(r_puntaje[11:8]), f_seg(r_puntaje[7:4]), f_seg(r_puntaje[3:0])};
`ifdef PUNTAJE_BLANK_CEROS_EN
    if (r_puntaje[11:8] == 4'd0) begin
      w_display[20:14] = 7'h00;
      if (r_puntaje[7:4] == 4'd0) w_display[13:7] = 7'h00;
    end
`endif
  end

  // All state: edge detect, score, saturation flag, record latch and display register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_puntaje <= '0;
      r_record  <= '0;
      r_nuevo   <= 1'b0;
      r_sat     <= 1'b0;
      r_punto_q <= 1'b0;
      r_estado  <= OFF;
      r_display <= DISPLAY_RESET;
    end else begin
      r_punto_q <= punto;
      r_estado  <= presente;
      r_puntaje <= w_siguiente;
      r_sat     <= (w_siguiente == MAX_BCD);
      r_display <= w_display;
      if (w_entra_wl) begin
        if (r_puntaje > r_record) begin
          r_record <= r_puntaje;
          r_nuevo  <= 1'b1;
        end else begin
          r_nuevo  <= 1'b0;
        end
      end else if (presente == CH) begin
        r_nuevo <= 1'b0;
      end
    end
  end

  assign display_puntaje = r_display;
  assign puntaje_bcd     = r_puntaje;
  assign record_bcd      = r_record;
  assign nuevo_record    = r_nuevo;
  assign saturado        = r_sat;

endmodule
